// File: rtl/ysyx_23060136_mul_pkg.sv
// Shared types and encodings for the EXU multiply requester.
// XLEN mirrors `ysyx_23060136_BITS_W.
package ysyx_23060136_mul_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mul_state_e;

    // funct3[1:0] of the RV64M multiply group
    localparam logic [1:0] MUL_OP_LO = 2'b00;
    localparam logic [1:0] MULH      = 2'b01;
    localparam logic [1:0] MULHSU    = 2'b10;
    localparam logic [1:0] MULHU     = 2'b11;

    // {src1_signed, src2_signed}
    localparam logic [1:0] SGN_SS = 2'b11;
    localparam logic [1:0] SGN_SU = 2'b10;
    localparam logic [1:0] SGN_UU = 2'b00;

    function automatic logic [1:0] op_sign(input logic [1:0] op, input logic w);
        logic [1:0] sgn;
        sgn = SGN_SS;
        if (!w) begin
            case (op)
                MULHSU:  sgn = SGN_SU;
                MULHU:   sgn = SGN_UU;
                default: sgn = SGN_SS;
            endcase
        end
        return sgn;
    endfunction

endpackage

// File: rtl/ysyx_23060136_exu_mul_fmt.sv
// Result formatter: picks the product half for the op and sign-extends MULW.
module ysyx_23060136_exu_mul_fmt
    import ysyx_23060136_mul_pkg::*;
#(
    parameter int FMT_W = XLEN
) (
    input  logic [1:0]       op,
    input  logic             w,
    input  logic [FMT_W-1:0] hi,
    input  logic [FMT_W-1:0] lo,
    output logic [FMT_W-1:0] result
);

    always_comb begin
        result = hi;
        if (w) begin
            result = {{(FMT_W-32){lo[31]}}, lo[31:0]};
        end else if (op == MUL_OP_LO) begin
            result = lo;
        end
    end

endmodule

// File: rtl/ysyx_23060136_exu_mul_req.sv
// Requester-side controller for the multiplier valid/ready/out_valid protocol.
// Optional result reuse for identical operand pairs: YSYX_23060136_MUL_FUSE_EN.
module ysyx_23060136_exu_mul_req
    import ysyx_23060136_mul_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_w,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            mul_valid,
    input  logic            mul_ready,
    output logic            mul_flush,
    output logic            mulw,
    output logic [1:0]      mul_signed,
    output logic [XLEN-1:0] multiplicand,
    output logic [XLEN-1:0] multiplier,
    input  logic            mul_out_valid,
    input  logic [XLEN-1:0] result_hi,
    input  logic [XLEN-1:0] result_lo,
    output mul_state_e      dbg_state
);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] src1_q, src2_q, out_result_q;
    logic [1:0]      op_q;
    logic            w_q;
    logic            accept, capture, fuse_hit;
    logic [1:0]      fmt_op;
    logic            fmt_w;
    logic [XLEN-1:0] fmt_hi, fmt_lo, fmt_result;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid and its payload stay stable until that edge, ready may change freely.
    assign in_ready     = (state_q == IDLE) && !flush;
    assign accept       = in_valid && in_ready;
    assign capture      = !flush && mul_out_valid &&
                          ((state_q == REQ && mul_ready) || state_q == WAIT);
    assign multiplicand = src1_q;
    assign multiplier   = src2_q;
    assign mulw         = w_q;
    assign mul_signed   = op_sign(op_q, w_q);
    assign out_result   = out_result_q;
    assign dbg_state    = state_q;

`ifdef YSYX_23060136_MUL_FUSE_EN
    logic [XLEN-1:0] fuse_src1, fuse_src2, fuse_hi, fuse_lo;
    logic [1:0]      fuse_sgn;
    logic            fuse_vld;

    assign fuse_hit = accept && !in_w && fuse_vld && in_src1 == fuse_src1 &&
                      in_src2 == fuse_src2 && op_sign(in_op, 1'b0) == fuse_sgn;
    assign fmt_op   = fuse_hit ? in_op   : op_q;
    assign fmt_w    = fuse_hit ? 1'b0    : w_q;
    assign fmt_hi   = fuse_hit ? fuse_hi : result_hi;
    assign fmt_lo   = fuse_hit ? fuse_lo : result_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fuse_src1 <= '0;
            fuse_src2 <= '0;
            fuse_hi   <= '0;
            fuse_lo   <= '0;
            fuse_sgn  <= '0;
            fuse_vld  <= 1'b0;
        end else if (flush || (accept && in_w) || (capture && w_q)) begin
            fuse_vld <= 1'b0;
        end else if (capture) begin
            fuse_src1 <= src1_q;
            fuse_src2 <= src2_q;
            fuse_hi   <= result_hi;
            fuse_lo   <= result_lo;
            fuse_sgn  <= mul_signed;
            fuse_vld  <= 1'b1;
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fmt_op   = op_q;
    assign fmt_w    = w_q;
    assign fmt_hi   = result_hi;
    assign fmt_lo   = result_lo;
`endif

    ysyx_23060136_exu_mul_fmt #(.FMT_W(XLEN)) u_fmt (
        .op     (fmt_op),
        .w      (fmt_w),
        .hi     (fmt_hi),
        .lo     (fmt_lo),
        .result (fmt_result)
    );

    always_comb begin
        state_d   = state_q;
        mul_valid = 1'b0;
        mul_flush = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = fuse_hit ? DONE : REQ;
            REQ: begin
                mul_valid = 1'b1;
                if (mul_ready) state_d = mul_out_valid ? DONE : WAIT;
            end
            WAIT: if (mul_out_valid) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Flush wins over everything; only an op still owned by the multiplier needs aborting.
        if (flush) begin
            state_d   = IDLE;
            mul_flush = (state_q == REQ) || (state_q == WAIT);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            src1_q       <= '0;
            src2_q       <= '0;
            op_q         <= '0;
            w_q          <= 1'b0;
            out_result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src1_q <= in_src1;
                src2_q <= in_src2;
                op_q   <= in_op;
                w_q    <= in_w;
            end
            if (capture || fuse_hit) out_result_q <= fmt_result;
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_exu_mul_req.sv
// Directed plus randomized bench for the multiply requester; the bench plays the multiplier.
module tb_ysyx_23060136_exu_mul_req;
    import ysyx_23060136_mul_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_w, flush, out_valid, out_ready;
    logic [1:0] in_op, mul_signed;
    logic [63:0] in_src1, in_src2, out_result, multiplicand, multiplier, result_hi, result_lo;
    logic mul_valid, mul_ready, mul_flush, mulw, mul_out_valid;
    mul_state_e dbg_state;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];

    ysyx_23060136_exu_mul_req dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_w(in_w), .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_flush(mul_flush), .mulw(mulw),
        .mul_signed(mul_signed), .multiplicand(multiplicand), .multiplier(multiplier),
        .mul_out_valid(mul_out_valid), .result_hi(result_hi), .result_lo(result_lo),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full 128-bit product with each operand extended per the op's signedness.
    task automatic ref_mul(input logic [1:0] op, input logic w, input logic [63:0] s1,
                           input logic [63:0] s2, output logic [63:0] hi,
                           output logic [63:0] lo, output logic [63:0] res,
                           output logic [1:0] sgn);
        logic [127:0] a, b, p;
        sgn = w ? 2'b11 : (op == 2'b10) ? 2'b10 : (op == 2'b11) ? 2'b00 : 2'b11;
        a = sgn[1] ? {{64{s1[63]}}, s1} : {64'd0, s1};
        b = sgn[0] ? {{64{s2[63]}}, s2} : {64'd0, s2};
        p = a * b;
        hi = p[127:64];
        lo = p[63:0];
        if (w) res = {{32{lo[31]}}, lo[31:0]};
        else if (op == 2'b00) res = lo;
        else res = hi;
    endtask

    task automatic accept_op(input logic [1:0] op, input logic w, input logic [63:0] s1,
                             input logic [63:0] s2);
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_w = w; in_src1 = s1; in_src2 = s2;
        #1 check("in_ready_idle", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; in_op = 2'($urandom); in_src1 = {$urandom, $urandom};
        in_src2 = {$urandom, $urandom};
    endtask

    // Full transaction with multiplier stall, multiplier latency and downstream stall.
    task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] s1,
                         input logic [63:0] s2, input int req_wait, input int lat,
                         input int out_wait);
        logic [63:0] hi, lo, res, exp;
        logic [1:0] sgn;
        ref_mul(op, w, s1, s2, hi, lo, res, sgn);
        exp_q.push_back(res);
        accept_op(op, w, s1, s2);
        for (int i = 0; i <= req_wait; i++) begin
            #1;
            check("mul_valid", mul_valid, 1'b1);
            check("multiplicand", multiplicand, s1);
            check("multiplier", multiplier, s2);
            check("mulw", mulw, w);
            check("mul_signed", mul_signed, sgn);
            if (i < req_wait) @(negedge clk);
        end
        mul_ready = 1'b1;
        if (lat == 0) begin
            mul_out_valid = 1'b1; result_hi = hi; result_lo = lo;
        end
        @(negedge clk);
        mul_ready = 1'b0; mul_out_valid = 1'b0;
        if (lat > 0) begin
            for (int i = 1; i < lat; i++) begin
                #1 check("mul_valid_wait", mul_valid, 1'b0);
                check("out_valid_wait", out_valid, 1'b0);
                @(negedge clk);
            end
            mul_out_valid = 1'b1; result_hi = hi; result_lo = lo;
            #1 check("out_valid_pre", out_valid, 1'b0);
            @(negedge clk);
            mul_out_valid = 1'b0;
        end
        result_hi = {$urandom, $urandom}; result_lo = {$urandom, $urandom};
        exp = exp_q.pop_front();
        #1 check("out_valid", out_valid, 1'b1);
        check("out_result", out_result, exp);
        for (int i = 0; i < out_wait; i++) begin
            @(negedge clk);
            #1 check("out_valid_hold", out_valid, 1'b1);
            check("out_result_hold", out_result, exp);
            check("in_ready_done", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1 check("out_valid_drop", out_valid, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
    endtask

    // Drive an op into DONE using a same-cycle accept/result from the multiplier.
    task automatic run_to_done(input logic [63:0] s1, input logic [63:0] s2);
        logic [63:0] hi, lo, res;
        logic [1:0] sgn;
        ref_mul(2'b00, 1'b0, s1, s2, hi, lo, res, sgn);
        accept_op(2'b00, 1'b0, s1, s2);
        mul_ready = 1'b1; mul_out_valid = 1'b1; result_hi = hi; result_lo = lo;
        @(negedge clk);
        mul_ready = 1'b0; mul_out_valid = 1'b0;
        #1 check("done_out_valid", out_valid, 1'b1);
        check("done_result", out_result, res);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_w = 1'b0; in_src1 = '0; in_src2 = '0;
        flush = 1'b0; out_ready = 1'b0; mul_ready = 1'b0; mul_out_valid = 1'b0;
        result_hi = '0; result_lo = '0;
        #2;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_mul_valid", mul_valid, 1'b0);
        check("rst_mul_flush", mul_flush, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_multiplicand", multiplicand, 64'd0);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        rst = 1'b1;

        // directed ops from the test plan, including 5-cycle and 4-cycle stalls
        do_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 2, 0);
        do_op(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5, 1, 4);
        do_op(2'b00, 1'b1, 64'h7FFF_FFFF, 64'd2, 0, 0, 0);
        do_op(2'b10, 1'b0, 64'h8000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFF0, 1, 3, 1);
        do_op(2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 0);

        // flush in WAIT, stale result 3 cycles later
        accept_op(2'b00, 1'b0, 64'd7, 64'd9);
        mul_ready = 1'b1;
        @(negedge clk);
        mul_ready = 1'b0; flush = 1'b1;
        #1 check("flush_wait_mul_flush", mul_flush, 1'b1);
        check("flush_wait_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_wait_pulse_end", mul_flush, 1'b0);
        check("flush_wait_state", dbg_state, IDLE);
        @(negedge clk);
        @(negedge clk);
        mul_out_valid = 1'b1; result_lo = 64'd63;
        @(negedge clk);
        mul_out_valid = 1'b0;
        #1 check("stale_out_valid", out_valid, 1'b0);
        check("stale_state", dbg_state, IDLE);

        // flush in REQ with a new op offered: abort and no accept
        accept_op(2'b01, 1'b0, 64'd3, 64'd4);
        flush = 1'b1; in_valid = 1'b1;
        #1 check("flush_req_mul_flush", mul_flush, 1'b1);
        check("flush_req_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 check("flush_req_state", dbg_state, IDLE);

        // flush in DONE discards without mul_flush
        run_to_done(64'd11, 64'd13);
        flush = 1'b1;
        #1 check("flush_done_mul_flush", mul_flush, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1 check("flush_done_out_valid", out_valid, 1'b0);

        // out_ready and in_valid together in DONE: no accept that cycle
        run_to_done(64'd5, 64'd6);
        out_ready = 1'b1; in_valid = 1'b1;
        #1 check("done_in_ready", in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b0;
        #1 check("done_release_state", dbg_state, IDLE);
        check("done_release_in_ready", in_ready, 1'b1);

        // MULH then MUL on the same operands
        do_op(2'b01, 1'b0, 64'd3, 64'd5, 0, 2, 0);
`ifdef YSYX_23060136_MUL_FUSE_EN
        accept_op(2'b00, 1'b0, 64'd3, 64'd5);
        #1 check("fuse_no_mul_valid", mul_valid, 1'b0);
        check("fuse_out_valid", out_valid, 1'b1);
        check("fuse_result", out_result, 64'd15);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
`else
        do_op(2'b00, 1'b0, 64'd3, 64'd5, 0, 2, 0);
`endif

        // randomized ops
        for (int n = 0; n < 20; n++) begin
            logic w;
            logic [1:0] op;
            w = 1'($urandom_range(0, 3) == 0);
            op = w ? 2'b00 : 2'($urandom_range(0, 3));
            do_op(op, w, {$urandom, $urandom}, {$urandom, $urandom},
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 2)));
        end

        // reset mid-operation
        accept_op(2'b00, 1'b0, 64'd21, 64'd2);
        rst = 1'b0;
        #1 check("midrst_state", dbg_state, IDLE);
        check("midrst_mul_valid", mul_valid, 1'b0);
        check("midrst_out_result", out_result, 64'd0);
        check("midrst_multiplicand", multiplicand, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
